adc_sample_fifo: RTL and testbench
==================================

ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 4..16).
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of samples per averaged output (1..4).
REQ-003 SHALL have port sclk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sample_in  input  12  unsigned ADC word from the serial receiver; stable whenever sample_tick is high.
REQ-006 SHALL have port sample_tick  input  1  sample-ready strobe from the serial receiver (rx_done_tick).
REQ-007 SHALL have port avg_en  input  1  1 = average 2^AVG_LOG2 samples per entry, 0 = bypass (one entry per sample).
REQ-008 SHALL have port rd_en  input  1  consumer pop request.
REQ-009 SHALL have port ovf_clr  input  1  clears sticky overflow.
REQ-010 SHALL have port dout  output  12  head-of-FIFO word, first-word-fall-through.
REQ-011 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-012 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-015 SHALL accept a sample only on the first cycle sample_tick is high after being low (rising-edge qualified); sample_tick held high for multiple cycles = one sample.
REQ-016 SHALL, with avg_en=0, push sample_in into the FIFO in the acceptance cycle.
REQ-017 SHALL, with avg_en=1, add each accepted sample into an unsigned accumulator of width 12+AVG_LOG2 and count accepted samples in a modulo-2^AVG_LOG2 counter.
REQ-018 SHALL, on the 2^AVG_LOG2-th accepted sample, push (accumulator + sample_in) >> AVG_LOG2 (truncating, never exceeding 12'hFFF) and clear accumulator and counter in the same cycle.
REQ-019 SHALL clear accumulator and sample counter, pushing nothing, in any cycle avg_en differs from its previous-cycle value; a sample accepted in that cycle is treated under the new mode as the first sample.
REQ-020 SHALL make a pushed entry visible (empty low, count incremented) in the cycle after the push cycle; dout SHALL present the oldest entry whenever empty=0.
REQ-021 SHALL pop the head on a rising edge with rd_en=1 and empty=0; rd_en with empty=1 SHALL be ignored with no state change.
REQ-022 SHALL, on simultaneous push and pop, perform both with count unchanged, including when full=1 (push not dropped).
REQ-023 SHALL, on push with full=1 and no pop, drop the word, leave FIFO contents unchanged and set overflow=1.
REQ-024 SHALL hold overflow until ovf_clr=1; a drop in the same cycle as ovf_clr SHALL leave overflow=1.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-026 SHALL hold dout at its last value while empty=1 (value undefined for the bench, not checked).

Reset
REQ-027 SHALL, on rst=1, immediately force empty=1, full=0, count=0, overflow=0, dout=12'h000, clear pointers, accumulator, sample counter, and edge-detect history (history=1, so a tick high during release is not accepted).
REQ-028 SHALL discard any partial average and all stored entries when rst asserts mid-operation.

Verification
REQ-029 Bypass: avg_en=0, ticks with 12'h123, 12'hABC -> empty falls one cycle after first tick, count=2, pops return 12'h123 then 12'hABC, then empty=1.
REQ-030 Average: avg_en=1, AVG_LOG2=2, samples 12'h004,12'h008,12'h00C,12'h011 -> single entry 12'h00A after 4th tick; 12'hFFF x4 -> 12'hFFF.
REQ-031 Tick qualification: sample_tick held high 5 cycles with 12'h055 -> count=1 only.
REQ-032 Overflow: DEPTH=8, 9 bypass pushes, no reads -> full=1, count=8, overflow=1, head still first sample; 9th push with rd_en same cycle on a full FIFO -> no drop, count stays 8; ovf_clr -> overflow=0.
REQ-033 Mode switch: avg_en=1, two samples, toggle avg_en to 0 -> no entry from the partial sum; next sample pushed directly.
REQ-034 Reset mid-operation: rst asserted with count=5 and a 3-sample partial average -> count=0, empty=1, overflow=0 asynchronously; next 4 averaged samples produce exactly one entry.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO: rising-edge-qualified sample capture, optional 2^AVG_LOG2 block
// averaging, and a first-word-fall-through FIFO with a sticky overflow flag.
module adc_sample_fifo #(
   parameter int DEPTH    = 8,
   parameter int AVG_LOG2 = 2
) (
   input  logic                     sclk,
   input  logic                     rst,
   input  logic [11:0]              sample_in,
   input  logic                     sample_tick,
   input  logic                     avg_en,
   input  logic                     rd_en,
   input  logic                     ovf_clr,
   output logic [11:0]              dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ACC_W = 12 + AVG_LOG2;
   localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]      CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
   localparam logic [AVG_LOG2-1:0] AVG_ONE  = AVG_LOG2'(1);

   logic                tick_hist_q, tick_hist_d;
   logic                avg_en_prev_q, avg_en_prev_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [AVG_LOG2-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [11:0]         mem_q [DEPTH];
   logic [11:0]         mem_d [DEPTH];

   logic                accept;
   logic                mode_chg;
   logic [ACC_W-1:0]    acc_base;
   logic [AVG_LOG2-1:0] cnt_base;
   logic [ACC_W-1:0]    sum;
   logic                push;
   logic [11:0]         push_data;
   logic                pop;
   logic                push_ok;
   logic                drop;
   logic                full_int;

   // A mode change wipes any partial average; a sample in that cycle starts fresh.
   always_comb begin
      accept        = sample_tick & ~tick_hist_q;
      mode_chg      = avg_en ^ avg_en_prev_q;
      acc_base      = mode_chg ? '0 : acc_q;
      cnt_base      = mode_chg ? '0 : cnt_q;
      sum           = acc_base + {{AVG_LOG2{1'b0}}, sample_in};
      acc_d         = acc_base;
      cnt_d         = cnt_base;
      push          = 1'b0;
      push_data     = sample_in;
      tick_hist_d   = sample_tick;
      avg_en_prev_d = avg_en;
      if (accept) begin
         if (!avg_en) begin
            push = 1'b1;
         end else if (cnt_base == '1) begin
            push      = 1'b1;
            push_data = sum[ACC_W-1:AVG_LOG2];
            acc_d     = '0;
            cnt_d     = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_base + AVG_ONE;
         end
      end
   end

   // A pop frees the head slot, so a push into a full FIFO in the same cycle is kept.
   always_comb begin
      full_int = (count_q == FULL_CNT);
      pop      = rd_en & (count_q != '0);
      push_ok  = push & (~full_int | pop);
      drop     = push & full_int & ~pop;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = (ovf_q & ~ovf_clr) | drop;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         tick_hist_q   <= 1'b1;
         avg_en_prev_q <= 1'b0;
         acc_q         <= '0;
         cnt_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         tick_hist_q   <= tick_hist_d;
         avg_en_prev_q <= avg_en_prev_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         mem_q         <= mem_d;
      end
   end

   assign dout     = mem_q[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign full     = full_int;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed testbench for adc_sample_fifo (DEPTH=8, AVG_LOG2=2); inputs change and
// outputs are checked on the falling edge of sclk.
module tb_adc_sample_fifo;

   logic        sclk = 1'b0;
   logic        rst;
   logic [11:0] sample_in;
   logic        sample_tick;
   logic        avg_en;
   logic        rd_en;
   logic        ovf_clr;
   logic [11:0] dout;
   logic        empty;
   logic        full;
   logic [3:0]  count;
   logic        overflow;

   int checks = 0;
   int fails  = 0;

   adc_sample_fifo #(.DEPTH(8), .AVG_LOG2(2)) dut (
      .sclk       (sclk),
      .rst        (rst),
      .sample_in  (sample_in),
      .sample_tick(sample_tick),
      .avg_en     (avg_en),
      .rd_en      (rd_en),
      .ovf_clr    (ovf_clr),
      .dout       (dout),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 sclk = ~sclk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge sclk);
   endtask

   task automatic tick(input logic [11:0] v);
      @(negedge sclk);
      sample_in   = v;
      sample_tick = 1'b1;
      @(negedge sclk);
      sample_tick = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge sclk);
      rd_en = 1'b1;
      @(negedge sclk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sample_in = '0; sample_tick = 1'b0;
      avg_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
      #3;
      checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (dout !== 12'h000) begin fails++; $display("[TB] FAIL reset_dout: got %h expected 000", dout); end
      // Tick already high while reset releases must not be accepted
      sample_in   = 12'h777;
      sample_tick = 1'b1;
      @(negedge sclk);
      rst = 1'b0;
      idle(3);
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL reset_release_tick: got %0d expected 0", count); end
      sample_tick = 1'b0;
      idle(1);
   endtask

   task automatic test_bypass();
      @(negedge sclk);
      sample_in   = 12'h123;
      sample_tick = 1'b1;
      checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL bypass_empty_before: got %b expected 1", empty); end
      @(negedge sclk);
      sample_tick = 1'b0;
      checks++; if (empty !== 1'b0) begin fails++; $display("[TB] FAIL bypass_empty_after: got %b expected 0", empty); end
      checks++; if (dout !== 12'h123) begin fails++; $display("[TB] FAIL bypass_head1: got %h expected 123", dout); end
      tick(12'hABC);
      checks++; if (count !== 4'd2) begin fails++; $display("[TB] FAIL bypass_count: got %0d expected 2", count); end
      checks++; if (dout !== 12'h123) begin fails++; $display("[TB] FAIL bypass_head_keep: got %h expected 123", dout); end
      pop_one();
      checks++; if (dout !== 12'hABC) begin fails++; $display("[TB] FAIL bypass_pop1: got %h expected abc", dout); end
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL bypass_count_pop1: got %0d expected 1", count); end
      pop_one();
      checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL bypass_empty_end: got %b expected 1", empty); end
      // Popping an empty FIFO must not disturb anything
      pop_one();
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL bypass_pop_empty: got %0d expected 0", count); end
   endtask

   task automatic test_average();
      @(negedge sclk);
      avg_en = 1'b1;
      idle(1);
      tick(12'h004);
      tick(12'h008);
      tick(12'h00C);
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL avg_partial: got %0d expected 0", count); end
      tick(12'h011);
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL avg_count: got %0d expected 1", count); end
      checks++; if (dout !== 12'h00A) begin fails++; $display("[TB] FAIL avg_value: got %h expected 00a", dout); end
      pop_one();
      repeat (4) tick(12'hFFF);
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL avg_max_count: got %0d expected 1", count); end
      checks++; if (dout !== 12'hFFF) begin fails++; $display("[TB] FAIL avg_max_value: got %h expected fff", dout); end
      pop_one();
   endtask

   task automatic test_tick_qual();
      @(negedge sclk);
      avg_en = 1'b0;
      @(negedge sclk);
      sample_in   = 12'h055;
      sample_tick = 1'b1;
      idle(5);
      sample_tick = 1'b0;
      idle(1);
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL tick_qual_count: got %0d expected 1", count); end
      checks++; if (dout !== 12'h055) begin fails++; $display("[TB] FAIL tick_qual_value: got %h expected 055", dout); end
      pop_one();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) tick(12'h101 + 12'(i));
      checks++; if (full !== 1'b1) begin fails++; $display("[TB] FAIL ovf_full: got %b expected 1", full); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_not_yet: got %b expected 0", overflow); end
      tick(12'h109);
      checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
      checks++; if (count !== 4'd8) begin fails++; $display("[TB] FAIL ovf_count: got %0d expected 8", count); end
      checks++; if (dout !== 12'h101) begin fails++; $display("[TB] FAIL ovf_head: got %h expected 101", dout); end
      // A drop coinciding with a clear keeps the flag set
      @(negedge sclk);
      sample_in = 12'h10A; sample_tick = 1'b1; ovf_clr = 1'b1;
      @(negedge sclk);
      sample_tick = 1'b0; ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_clr_with_drop: got %b expected 1", overflow); end
      @(negedge sclk);
      ovf_clr = 1'b1;
      @(negedge sclk);
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clr: got %b expected 0", overflow); end
      @(negedge sclk);
      sample_in = 12'h1AA; sample_tick = 1'b1; rd_en = 1'b1;
      @(negedge sclk);
      sample_tick = 1'b0; rd_en = 1'b0;
      checks++; if (count !== 4'd8) begin fails++; $display("[TB] FAIL simul_count: got %0d expected 8", count); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL simul_no_drop: got %b expected 0", overflow); end
      checks++; if (dout !== 12'h102) begin fails++; $display("[TB] FAIL simul_head: got %h expected 102", dout); end
      repeat (7) pop_one();
      checks++; if (dout !== 12'h1AA) begin fails++; $display("[TB] FAIL simul_tail: got %h expected 1aa", dout); end
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL drain_count: got %0d expected 1", count); end
      pop_one();
      checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
   endtask

   task automatic test_mode_switch();
      @(negedge sclk);
      avg_en = 1'b1;
      idle(1);
      tick(12'h010);
      tick(12'h020);
      @(negedge sclk);
      avg_en = 1'b0;
      idle(1);
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL mode_no_partial: got %0d expected 0", count); end
      tick(12'h333);
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL mode_direct_count: got %0d expected 1", count); end
      checks++; if (dout !== 12'h333) begin fails++; $display("[TB] FAIL mode_direct_value: got %h expected 333", dout); end
      pop_one();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) tick(12'h200 + 12'(i));
      @(negedge sclk);
      avg_en = 1'b1;
      idle(1);
      repeat (3) tick(12'h400);
      checks++; if (count !== 4'd5) begin fails++; $display("[TB] FAIL mid_pre_count: got %0d expected 5", count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL mid_rst_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL mid_rst_empty: got %b expected 1", empty); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_overflow: got %b expected 0", overflow); end
      @(negedge sclk);
      rst = 1'b0;
      idle(1);
      tick(12'h010);
      tick(12'h020);
      tick(12'h030);
      checks++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL mid_partial_discarded: got %0d expected 0", count); end
      tick(12'h040);
      checks++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL mid_avg_count: got %0d expected 1", count); end
      checks++; if (dout !== 12'h028) begin fails++; $display("[TB] FAIL mid_avg_value: got %h expected 028", dout); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_average();
      test_tick_qual();
      test_overflow();
      test_mode_switch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
